// File: rtl/slant_pkg.sv
// Shared constants and the FSM state encoding for the slant link transmitter.
package slant_pkg;

  localparam logic [23:0] SYNC_FRAME_EVEN = 24'hAAB155;
  localparam logic [23:0] SYNC_FRAME_ODD  = 24'hAA8D55;
  localparam logic [23:0] SYNC_HSYNC      = 24'h00A355;

  // Number of bit periods in every sync word.
  localparam int SYNC_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    FSYNC,
    HSYNC,
    DATA,
    PARITY
  } txState_t;

endpackage

// File: rtl/slant_bit_timer.sv
// Bit-period timer: counts 0..BIT_TIME-1 and flags the last clock of each bit.
// Holding clear keeps the count at zero so the first period after release is full length.
module slant_bit_timer #(
  parameter int BIT_TIME = 25
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = (BIT_TIME > 1) ? $clog2(BIT_TIME) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(BIT_TIME - 1);

  logic [CW-1:0] count;

  // Free-running period counter, restarted by clear or at the end of each bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear || (count == LAST_COUNT)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign bit_tick = (count == LAST_COUNT) && !clear;

endmodule

// File: rtl/slant_transmitter.sv
// Slant link transmitter: serialises a video frame onto four 8-bit sample lanes.
// A frame is an FSYNC word, then per line an HSYNC word followed by nibble-parallel
// pixel data (low nibble first). Lane registers only change at bit boundaries.
// Optional feature: define SLANT_TX_PARITY_EN to append one even-parity bit period
// per lane after the data of every line.
module slant_transmitter
  import slant_pkg::*;
#(
  parameter int         BIT_TIME   = 25,
  parameter int         LINE_BYTES = 160,
  parameter int         LINES      = 120,
  parameter logic [7:0] HIGH_LVL   = 8'hC0,
  parameter logic [7:0] LOW_LVL    = 8'h40
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       frame_start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] Transmit0Data,
  output logic [7:0] Transmit1Data,
  output logic [7:0] Transmit2Data,
  output logic [7:0] Transmit3Data,
  output logic       busy,
  output logic       frame_odd,
  output logic       underrun
);

  localparam int DATA_PERIODS = 2 * LINE_BYTES;
  localparam int MAX_PERIODS  = (DATA_PERIODS > SYNC_BITS) ? DATA_PERIODS : SYNC_BITS;
  localparam int IW           = $clog2(MAX_PERIODS);
  localparam int LW           = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [IW-1:0] LAST_SYNC_IDX = IW'(SYNC_BITS - 1);
  localparam logic [IW-1:0] LAST_DATA_IDX = IW'(DATA_PERIODS - 1);
  localparam logic [LW-1:0] LAST_LINE     = LW'(LINES - 1);

  txState_t      state, nextState;
  logic [IW-1:0] bitIdx, nextBitIdx;
  logic [LW-1:0] lineCnt, nextLineCnt;
  logic [23:0]   syncShift, nextSyncShift;
  logic [3:0]    laneBits, nextLaneBits;
  logic [3:0]    hiNibble, nextHiNibble;
  logic          nextBusy, nextFrameOdd, nextUnderrun;
  logic          bitTick, fetch, lineDone;
  logic [7:0]    fetchByte;
  logic [23:0]   frameSync;
`ifdef SLANT_TX_PARITY_EN
  logic [3:0]    parAcc, nextParAcc;
`endif

  slant_bit_timer #(
    .BIT_TIME(BIT_TIME)
  ) bitTimer (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (state == IDLE),
    .bit_tick(bitTick)
  );

  // Next-state, serialiser and byte-fetch decisions; everything holds unless a bit ends.
  always_comb begin
    nextState     = state;
    nextBitIdx    = bitIdx;
    nextLineCnt   = lineCnt;
    nextSyncShift = syncShift;
    nextLaneBits  = laneBits;
    nextHiNibble  = hiNibble;
    nextBusy      = busy;
    nextFrameOdd  = frame_odd;
    nextUnderrun  = underrun;
`ifdef SLANT_TX_PARITY_EN
    nextParAcc    = parAcc;
`endif
    fetch     = 1'b0;
    lineDone  = 1'b0;
    fetchByte = s_valid ? s_data : 8'h00;
    frameSync = frame_odd ? SYNC_FRAME_EVEN : SYNC_FRAME_ODD;

    case (state)
      IDLE: begin
        if (frame_start) begin
          nextState     = FSYNC;
          nextBitIdx    = '0;
          nextLineCnt   = '0;
          nextFrameOdd  = ~frame_odd;
          nextUnderrun  = 1'b0;
          nextBusy      = 1'b1;
          nextLaneBits  = {4{frameSync[23]}};
          nextSyncShift = {frameSync[22:0], 1'b0};
        end
      end

      FSYNC: begin
        if (bitTick) begin
          if (bitIdx == LAST_SYNC_IDX) begin
            nextState     = HSYNC;
            nextBitIdx    = '0;
            nextLaneBits  = {4{SYNC_HSYNC[23]}};
            nextSyncShift = {SYNC_HSYNC[22:0], 1'b0};
          end else begin
            nextBitIdx    = bitIdx + IW'(1);
            nextLaneBits  = {4{syncShift[23]}};
            nextSyncShift = {syncShift[22:0], 1'b0};
          end
        end
      end

      HSYNC: begin
        if (bitTick) begin
          if (bitIdx == LAST_SYNC_IDX) begin
            nextState    = DATA;
            nextBitIdx   = '0;
            fetch        = 1'b1;
            nextLaneBits = fetchByte[3:0];
            nextHiNibble = fetchByte[7:4];
`ifdef SLANT_TX_PARITY_EN
            nextParAcc   = fetchByte[3:0];
`endif
          end else begin
            nextBitIdx    = bitIdx + IW'(1);
            nextLaneBits  = {4{syncShift[23]}};
            nextSyncShift = {syncShift[22:0], 1'b0};
          end
        end
      end

      DATA: begin
        if (bitTick) begin
          if (bitIdx == LAST_DATA_IDX) begin
`ifdef SLANT_TX_PARITY_EN
            nextState    = PARITY;
            nextBitIdx   = '0;
            nextLaneBits = parAcc;
`else
            lineDone     = 1'b1;
`endif
          end else begin
            nextBitIdx = bitIdx + IW'(1);
            if (!bitIdx[0]) begin
              nextLaneBits = hiNibble;
`ifdef SLANT_TX_PARITY_EN
              nextParAcc   = parAcc ^ hiNibble;
`endif
            end else begin
              fetch        = 1'b1;
              nextLaneBits = fetchByte[3:0];
              nextHiNibble = fetchByte[7:4];
`ifdef SLANT_TX_PARITY_EN
              nextParAcc   = parAcc ^ fetchByte[3:0];
`endif
            end
          end
        end
      end

      PARITY: begin
        if (bitTick) begin
          lineDone = 1'b1;
        end
      end

      default: begin
        nextState = IDLE;
      end
    endcase

    if (fetch && !s_valid) begin
      nextUnderrun = 1'b1;
    end

    if (lineDone) begin
      nextBitIdx = '0;
      if (lineCnt == LAST_LINE) begin
        nextState    = IDLE;
        nextBusy     = 1'b0;
        nextLaneBits = '0;
      end else begin
        nextState     = HSYNC;
        nextLineCnt   = lineCnt + LW'(1);
        nextLaneBits  = {4{SYNC_HSYNC[23]}};
        nextSyncShift = {SYNC_HSYNC[22:0], 1'b0};
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Datapath registers: counters, shift word, lane bits and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bitIdx    <= '0;
      lineCnt   <= '0;
      syncShift <= '0;
      laneBits  <= '0;
      hiNibble  <= '0;
      busy      <= 1'b0;
      frame_odd <= 1'b1;
      underrun  <= 1'b0;
`ifdef SLANT_TX_PARITY_EN
      parAcc    <= '0;
`endif
    end else begin
      bitIdx    <= nextBitIdx;
      lineCnt   <= nextLineCnt;
      syncShift <= nextSyncShift;
      laneBits  <= nextLaneBits;
      hiNibble  <= nextHiNibble;
      busy      <= nextBusy;
      frame_odd <= nextFrameOdd;
      underrun  <= nextUnderrun;
`ifdef SLANT_TX_PARITY_EN
      parAcc    <= nextParAcc;
`endif
    end
  end

  assign s_ready       = fetch;
  assign Transmit0Data = laneBits[0] ? HIGH_LVL : LOW_LVL;
  assign Transmit1Data = laneBits[1] ? HIGH_LVL : LOW_LVL;
  assign Transmit2Data = laneBits[2] ? HIGH_LVL : LOW_LVL;
  assign Transmit3Data = laneBits[3] ? HIGH_LVL : LOW_LVL;

endmodule

// File: tb/tb_slant_transmitter.sv
// Testbench for slant_transmitter with a small frame (2 lines of 2 bytes).
// Each frame launch pushes the expected lane pattern of every bit period into a
// queue; an independent monitor pops one entry per bit period and compares.
// Honours SLANT_TX_PARITY_EN when the design is built with it.
module tb_slant_transmitter;

  localparam int BT = 25;
  localparam int LB = 2;
  localparam int NL = 2;
  localparam logic [7:0]  HI_LVL    = 8'hC0;
  localparam logic [7:0]  LO_LVL    = 8'h40;
  localparam logic [23:0] EVEN_WORD = 24'hAAB155;
  localparam logic [23:0] ODD_WORD  = 24'hAA8D55;
  localparam logic [23:0] LINE_WORD = 24'h00A355;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] Transmit0Data, Transmit1Data, Transmit2Data, Transmit3Data;
  logic       busy, frame_odd, underrun;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] expQ[$];
  logic [8:0] planQ[$];
  int         expCycles  = 0;
  int         expStrobes = 0;
  logic       expOdd = 1'b0;
  logic       expUnderrun = 1'b0;
  logic       nextOdd = 1'b0;

  slant_transmitter #(
    .BIT_TIME  (BT),
    .LINE_BYTES(LB),
    .LINES     (NL),
    .HIGH_LVL  (HI_LVL),
    .LOW_LVL   (LO_LVL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .Transmit0Data(Transmit0Data),
    .Transmit1Data(Transmit1Data),
    .Transmit2Data(Transmit2Data),
    .Transmit3Data(Transmit3Data),
    .busy         (busy),
    .frame_odd    (frame_odd),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Four lane bits to the four lane sample levels, lane0 in the low byte.
  function automatic logic [31:0] lanesOf(input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = b[i] ? HI_LVL : LO_LVL;
    return r;
  endfunction

  // Plan a frame, queue its expected bit periods and pulse frame_start.
  // mode 0: first line A5,3C then random valid; 1: random with gaps; 2: no data.
  task automatic applyStimulus(input int mode);
    logic [23:0] word;
    logic [7:0]  d;
    logic [7:0]  val;
    logic        v;
    logic [3:0]  par;
    int          periods;
    expOdd  = nextOdd;
    nextOdd = ~nextOdd;
    word    = expOdd ? ODD_WORD : EVEN_WORD;
    expUnderrun = 1'b0;
    periods = 0;
    for (int i = 0; i < 24; i++) begin
      expQ.push_back({4{word[23-i]}});
      periods++;
    end
    for (int ln = 0; ln < NL; ln++) begin
      word = LINE_WORD;
      for (int i = 0; i < 24; i++) begin
        expQ.push_back({4{word[23-i]}});
        periods++;
      end
      par = 4'h0;
      for (int b = 0; b < LB; b++) begin
        d = 8'($urandom_range(0, 255));
        if (mode == 0 && ln == 0) begin
          v = 1'b1;
          d = (b == 0) ? 8'hA5 : 8'h3C;
        end else if (mode == 2) begin
          v = 1'b0;
        end else if (mode == 1) begin
          v = ($urandom_range(0, 3) != 0);
        end else begin
          v = 1'b1;
        end
        planQ.push_back({v, d});
        val = v ? d : 8'h00;
        if (!v) expUnderrun = 1'b1;
        expQ.push_back(val[3:0]);
        expQ.push_back(val[7:4]);
        par = par ^ val[3:0] ^ val[7:4];
        periods += 2;
      end
`ifdef SLANT_TX_PARITY_EN
      expQ.push_back(par);
      periods++;
`endif
    end
    expCycles  = periods * BT;
    expStrobes = NL * LB;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  // Run out the frame, optionally pulsing frame_start mid-frame and on the busy-fall edge.
  task automatic finishFrame(input bit midPulse, input bit edgePulse);
    int waited;
    for (int c = 1; c < expCycles; c++) begin
      @(posedge clk);
      #1;
      frame_start = (midPulse && c == expCycles / 3) || (edgePulse && c == expCycles - 1);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    waited = 0;
    while (busy && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    checkOutput("frameEndsInTime", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("stillIdleAfterEnd", 32'(busy), 32'd0);
  endtask

  // Byte source: presents the planned byte and advances once it is strobed.
  initial begin
    logic take;
    forever begin
      @(negedge clk);
      take = s_ready && rstn;
      @(posedge clk);
      #1;
      if (take && planQ.size() > 0) void'(planQ.pop_front());
      if (planQ.size() > 0) begin
        s_valid = planQ[0][8];
        s_data  = planQ[0][7:0];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom_range(0, 255));
      end
    end
  end

  // Monitor: idle checks, one lane comparison mid-way through every bit period,
  // and frame-level checks when busy drops.
  initial begin
    int cyc;
    int period;
    int busyCycles;
    int strobes;
    bit inFrame;
    logic [3:0] e;
    cyc = 0; period = 0; busyCycles = 0; strobes = 0; inFrame = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) begin
        if (inFrame && rstn) begin
          checkOutput("busyCycles", busyCycles, expCycles);
          checkOutput("leftoverPeriods", expQ.size(), 32'd0);
          checkOutput("strobeCount", strobes, expStrobes);
          checkOutput("underrunAtEnd", 32'(underrun), 32'(expUnderrun));
        end
        inFrame = 1'b0;
        checkOutput("idleLanes", {Transmit3Data, Transmit2Data, Transmit1Data, Transmit0Data},
                    {4{LO_LVL}});
        checkOutput("idleReady", 32'(s_ready), 32'd0);
      end else begin
        if (!inFrame) begin
          inFrame = 1'b1;
          cyc = 0; period = 0; busyCycles = 0; strobes = 0;
        end
        busyCycles++;
        if (s_ready) begin
          strobes++;
          checkOutput("strobeAtBitEdge", cyc, BT - 1);
        end
        if (cyc == BT / 2) begin
          checkOutput("periodExpected", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("lanes[p%0d]", period),
                        {Transmit3Data, Transmit2Data, Transmit1Data, Transmit0Data}, lanesOf(e));
          end
          if (period == 0) begin
            checkOutput("frameOddInFlight", 32'(frame_odd), 32'(expOdd));
            checkOutput("underrunClearedOnStart", 32'(underrun), 32'd0);
          end
          period++;
        end
        cyc = (cyc == BT - 1) ? 0 : cyc + 1;
      end
    end
  end

  // Directed sequence of frames around the randomized byte plans.
  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    checkOutput("resetFrameOdd", 32'(frame_odd), 32'd1);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetUnderrun", 32'(underrun), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    applyStimulus(0);
    finishFrame(1'b0, 1'b0);
    checkOutput("frameOddAfterFirst", 32'(frame_odd), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    applyStimulus(1);
    finishFrame(1'b1, 1'b1);
    checkOutput("frameOddAfterSecond", 32'(frame_odd), 32'd1);

    repeat (5) @(posedge clk);
    #1;
    applyStimulus(2);
    finishFrame(1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("underrunSticky", 32'(underrun), 32'd1);

    applyStimulus(1);
    finishFrame(1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    applyStimulus(0);
    repeat ((48 + 1) * BT + 10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midResetLanes", {Transmit3Data, Transmit2Data, Transmit1Data, Transmit0Data},
                {4{LO_LVL}});
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetReady", 32'(s_ready), 32'd0);
    checkOutput("midResetFrameOdd", 32'(frame_odd), 32'd1);
    expQ.delete();
    planQ.delete();
    nextOdd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(1);
    finishFrame(1'b0, 1'b0);
    checkOutput("evenAfterReset", 32'(frame_odd), 32'd0);

    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
